// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage driving an SRAM-like data port.
// Optional feature: define MEM_ALIGN_CHECK_EN to raise adel/ades on misaligned
// accesses instead of issuing them.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         MEM_valid,
    input  logic [166:0] EXE_MEM_bus_r,
    input  logic         MEM_allow_out,
    output logic         MEM_over,
    output logic [159:0] MEM_WB_bus,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_result_quick_get,
    output logic         MEM_quick_en,
    output logic [31:0]  MEM_pc,
    output logic         data_req,
    output logic         data_wr,
    output logic [1:0]   data_size,
    output logic [31:0]  data_addr,
    output logic [31:0]  data_wdata,
    input  logic         data_addr_ok,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;

    logic [5:0]  mem_control, hilo_ctl, exc_bits;
    logic [31:0] store_data, exe_result, lo_result, pc;
    logic        data_related_en, is_ds;
    logic [7:0]  cp0r_addr;
    logic [1:0]  halfword;
    logic [3:0]  rf_wen;
    logic [4:0]  rf_wdest;
    logic        load, store, sign_ext, misaligned, adel, ades, capture, unused;
    logic [1:0]  size, state_q, state_d;
    logic [31:0] load_q, load_d, bad_vaddr, load_value, mem_result;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign {mem_control, store_data, data_related_en, exe_result, lo_result, hilo_ctl,
            cp0r_addr, exc_bits, is_ds, halfword, rf_wen, rf_wdest, pc} = EXE_MEM_bus_r;
    assign unused = ^{halfword, mem_control[0]};

    assign load     = mem_control[5];
    assign store    = mem_control[4];
    assign size     = mem_control[3:2];
    assign sign_ext = mem_control[1];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (load | store) & ((size == 2'b01) ? exe_result[0] : (size[1] & |exe_result[1:0]));
`else
    assign misaligned = 1'b0;
`endif
    assign adel      = misaligned & load;
    assign ades      = misaligned & store;
    assign bad_vaddr = misaligned ? exe_result : 32'd0;

    // Aligned accesses go through REQ/WAIT; anything else finishes after one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (MEM_valid) state_d = ((load | store) & ~misaligned) ? REQ : DONE;
            REQ:     if (data_addr_ok) state_d = data_data_ok ? DONE : WAIT;
            WAIT:    if (data_data_ok) state_d = DONE;
            default: if (MEM_allow_out) state_d = IDLE;
        endcase
    end

    // Responses only count once the request has been accepted
    assign capture = ((state_q == REQ) & data_addr_ok | (state_q == WAIT)) & data_data_ok;
    assign load_d  = capture ? data_rdata : load_q;

    // State and captured read data; reset also abandons an in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

    assign lane_byte  = load_q[{exe_result[1:0], 3'b000} +: 8];
    assign lane_half  = exe_result[1] ? load_q[31:16] : load_q[15:0];
    assign load_value = (size == 2'b00) ? {{24{sign_ext & lane_byte[7]}}, lane_byte} :
                        (size == 2'b01) ? {{16{sign_ext & lane_half[15]}}, lane_half} : load_q;
    assign mem_result = load ? load_value : exe_result;

    assign data_req   = state_q == REQ;
    assign data_wr    = store;
    assign data_size  = size;
    assign data_addr  = exe_result;
    assign data_wdata = (size == 2'b00) ? {4{store_data[7:0]}} :
                        (size == 2'b01) ? {2{store_data[15:0]}} : store_data;

    assign MEM_over             = (state_q == DONE) & MEM_valid;
    assign MEM_wdest            = rf_wdest & {5{MEM_valid}};
    assign MEM_result_quick_get = mem_result;
    assign MEM_quick_en         = MEM_valid & data_related_en & (~load | (state_q == DONE));
    assign MEM_pc               = pc;
    assign MEM_WB_bus           = {rf_wen, rf_wdest, mem_result, lo_result, hilo_ctl, cp0r_addr,
                                   exc_bits, adel, ades, is_ds, pc, bad_vaddr};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, corner-case sequences and random traffic for mem_stage.
module tb_mem_stage;
    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] sd;
        logic        dre;
        logic [31:0] exe;
        logic [31:0] lo;
        logic [5:0]  hl;
        logic [7:0]  cp0;
        logic [5:0]  exc;
        logic        is_ds;
        logic [1:0]  hw;
        logic [3:0]  wen;
        logic [4:0]  wd;
        logic [31:0] pc;
    } exe_t;

    typedef struct packed {
        logic [3:0]  wen;
        logic [4:0]  wd;
        logic [31:0] res;
        logic [31:0] lo;
        logic [5:0]  hl;
        logic [7:0]  cp0;
        logic [5:0]  exc;
        logic        adel;
        logic        ades;
        logic        is_ds;
        logic [31:0] pc;
        logic [31:0] bv;
    } wb_t;

    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] sd;
        logic [31:0] addr;
        logic [31:0] rd;
        int          ad;
        int          dd;
        int          done;
        logic [31:0] res;
        logic [31:0] wd;
    } vec_t;

    logic         clk = 1'b0, reset = 1'b1, MEM_valid = 1'b0, MEM_allow_out = 1'b0;
    logic [166:0] EXE_MEM_bus_r = '0;
    logic         MEM_over, MEM_quick_en, data_req, data_wr;
    logic [159:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_result_quick_get, MEM_pc, data_addr, data_wdata;
    logic [1:0]   data_size;
    logic         data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0]  data_rdata = '0;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] last_rd = '0;

    mem_stage dut (
        .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(EXE_MEM_bus_r),
        .MEM_allow_out(MEM_allow_out), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
        .MEM_wdest(MEM_wdest), .MEM_result_quick_get(MEM_result_quick_get),
        .MEM_quick_en(MEM_quick_en), .MEM_pc(MEM_pc), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One instruction through the stage with a scheduled SRAM: addr_ok after ad REQ cycles,
    // data_ok dd cycles after acceptance, MEM_allow_out held off for hold DONE cycles.
    task automatic run(input exe_t e, input logic [31:0] rd, input int ad, input int dd, input int hold,
                       output int done_seen, output logic [31:0] res_seen, output logic [31:0] wd_seen);
        logic        ld, st, mis, acc;
        logic [31:0] a, src, v, exp_wd;
        int          sz, dc;
        wb_t         w;
        a  = e.exe;
        ld = e.ctl[5];
        st = e.ctl[4];
        sz = int'(e.ctl[3:2]);
`ifdef MEM_ALIGN_CHECK_EN
        mis = (ld || st) && ((sz == 1 && a[0]) || (sz >= 2 && a[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        acc = (ld || st) && !mis;
        dc  = acc ? 2 + ad + dd : 1;
        src = acc ? rd : last_rd;
        v   = (sz == 0) ? ((src >> (8 * int'(a[1:0]))) & 32'hFF) :
              (sz == 1) ? ((src >> (16 * int'(a[1]))) & 32'hFFFF) : src;
        if (e.ctl[1] && sz == 0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        if (e.ctl[1] && sz == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        exp_wd = (sz == 0) ? {4{e.sd[7:0]}} : (sz == 1) ? {2{e.sd[15:0]}} : e.sd;
        w.wen = e.wen; w.wd = e.wd; w.res = ld ? v : a; w.lo = e.lo; w.hl = e.hl;
        w.cp0 = e.cp0; w.exc = e.exc; w.adel = mis && ld; w.ades = mis && st;
        w.is_ds = e.is_ds; w.pc = e.pc; w.bv = mis ? a : 32'd0;
        done_seen = -1; res_seen = '0; wd_seen = '0;
        EXE_MEM_bus_r = e;
        MEM_valid = 1'b1;
        for (int c = 0; c <= dc + hold; c++) begin
            data_addr_ok  = acc && c == 1 + ad;
            data_data_ok  = (acc && c == 1 + ad + dd) || ((c == 0 || (acc && c <= ad)) && $urandom_range(1) == 1);
            data_rdata    = (acc && c == 1 + ad + dd) ? rd : $urandom;
            MEM_allow_out = (c < dc) ? ($urandom_range(1) == 1) : (c == dc + hold);
            #1;
            chk("data_req", 192'(data_req), 192'(acc && c >= 1 && c <= 1 + ad));
            chk("MEM_over", 192'(MEM_over), 192'(c >= dc));
            if (MEM_over && done_seen < 0) done_seen = c;
            if (c == 0) begin
                chk("quick_en_entry", 192'(MEM_quick_en), 192'(e.dre && !ld));
                chk("MEM_wdest", 192'(MEM_wdest), 192'(e.wd));
                chk("MEM_pc", 192'(MEM_pc), 192'(e.pc));
            end
            if (acc && c == 1) begin
                chk("data_addr", 192'(data_addr), 192'(a));
                chk("data_size", 192'(data_size), 192'(e.ctl[3:2]));
                chk("data_wr", 192'(data_wr), 192'(st));
                chk("data_wdata", 192'(data_wdata), 192'(exp_wd));
                wd_seen = data_wdata;
            end
            if (c == dc) begin
                chk("MEM_WB_bus", 192'(MEM_WB_bus), 192'(w));
                chk("quick_get", 192'(MEM_result_quick_get), 192'(w.res));
                chk("quick_en_done", 192'(MEM_quick_en), 192'(e.dre));
                res_seen = MEM_result_quick_get;
            end
            @(negedge clk);
        end
        if (acc) last_rd = rd;
        MEM_allow_out = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
    endtask

    initial begin
        vec_t        tbl[9];
        exe_t        e, base;
        logic [191:0] tmp;
        int          dn;
        logic [31:0] res, wd;

        tbl[0] = '{6'b101000, 32'h0,        32'h100, 32'hDEADBEEF, 0, 2, 4, 32'hDEADBEEF, 32'h0};
`ifdef MEM_ALIGN_CHECK_EN
        tbl[1] = '{6'b101000, 32'h0,        32'h101, 32'h11223344, 0, 0, 1, 32'hDEADBEEF, 32'h0};
`else
        tbl[1] = '{6'b101000, 32'h0,        32'h101, 32'h11223344, 0, 0, 2, 32'h11223344, 32'h0};
`endif
        tbl[2] = '{6'b100010, 32'h0,        32'h103, 32'h80112233, 1, 1, 4, 32'hFFFFFF80, 32'h0};
        tbl[3] = '{6'b100000, 32'h0,        32'h103, 32'h80112233, 2, 0, 4, 32'h00000080, 32'h0};
        tbl[4] = '{6'b010100, 32'h1234ABCD, 32'h202, 32'h0,        0, 0, 2, 32'h00000202, 32'hABCDABCD};
        tbl[5] = '{6'b000000, 32'h0,   32'hCAFEF00D, 32'h0,        0, 0, 1, 32'hCAFEF00D, 32'h0};
        tbl[6] = '{6'b100110, 32'h0,        32'h102, 32'h80017FFF, 0, 1, 3, 32'hFFFF8001, 32'h0};
        tbl[7] = '{6'b010000, 32'h000000A5, 32'h001, 32'h0,        1, 0, 3, 32'h00000001, 32'hA5A5A5A5};
        tbl[8] = '{6'b011000, 32'h01020304, 32'h3FC, 32'h0,        0, 3, 5, 32'h000003FC, 32'h01020304};

        base = '0;
        base.dre = 1'b1; base.lo = 32'h0BAD1111; base.hl = 6'b101010; base.cp0 = 8'h5C;
        base.exc = 6'b010011; base.is_ds = 1'b1; base.hw = 2'b11; base.wen = 4'hF; base.wd = 5'd7;

        // reset, then an idle stage must stay put and ignore stray responses
        repeat (2) @(negedge clk);
        reset = 1'b0;
        e = base; e.ctl = 6'b101000; e.exe = 32'h40;
        EXE_MEM_bus_r = e;
        for (int c = 0; c < 3; c++) begin
            data_data_ok = 1'b1;
            data_rdata   = $urandom;
            #1;
            chk("idle data_req", 192'(data_req), 192'(0));
            chk("idle MEM_over", 192'(MEM_over), 192'(0));
            chk("idle MEM_wdest", 192'(MEM_wdest), 192'(0));
            if (c == 0) chk("reset load reg", 192'(MEM_result_quick_get), 192'(0));
            @(negedge clk);
        end
        data_data_ok = 1'b0;

        // vector table
        for (int i = 0; i < 9; i++) begin
            e = base;
            e.ctl = tbl[i].ctl; e.sd = tbl[i].sd; e.exe = tbl[i].addr; e.pc = 32'hBFC00000 + 32'(16 * i);
            run(e, tbl[i].rd, tbl[i].ad, tbl[i].dd, i % 3, dn, res, wd);
            chk($sformatf("vec%0d done_cycle", i), 192'(dn), 192'(tbl[i].done));
            chk($sformatf("vec%0d mem_result", i), 192'(res), 192'(tbl[i].res));
            if (tbl[i].ctl[4]) chk($sformatf("vec%0d wdata", i), 192'(wd), 192'(tbl[i].wd));
        end
        MEM_valid = 1'b0;
        @(negedge clk);

        // MEM_valid dropping after acceptance must not abort the access
        e = base; e.ctl = 6'b101000; e.exe = 32'h80;
        EXE_MEM_bus_r = e; MEM_valid = 1'b1;
        #1 chk("drop c0 data_req", 192'(data_req), 192'(0));
        @(negedge clk); data_addr_ok = 1'b1;
        #1 chk("drop c1 data_req", 192'(data_req), 192'(1));
        @(negedge clk); data_addr_ok = 1'b0; MEM_valid = 1'b0;
        #1 chk("drop c2 data_req", 192'(data_req), 192'(0));
        @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h13579BDF;
        #1 chk("drop c3 MEM_over", 192'(MEM_over), 192'(0));
        @(negedge clk); data_data_ok = 1'b0; data_rdata = $urandom;
        #1 chk("drop c4 MEM_over", 192'(MEM_over), 192'(0));
        chk("drop c4 data_req", 192'(data_req), 192'(0));
        @(negedge clk); MEM_valid = 1'b1; MEM_allow_out = 1'b1;
        #1 chk("drop c5 MEM_over", 192'(MEM_over), 192'(1));
        chk("drop c5 result", 192'(MEM_result_quick_get), 192'(32'h13579BDF));
        @(negedge clk); MEM_allow_out = 1'b0; MEM_valid = 1'b0;
        #1 chk("drop c6 MEM_over", 192'(MEM_over), 192'(0));
        last_rd = 32'h13579BDF;
        @(negedge clk);

        // reset while waiting for data; the late response must be ignored
        e = base; e.ctl = 6'b101000; e.exe = 32'h40;
        EXE_MEM_bus_r = e; MEM_valid = 1'b1;
        @(negedge clk); data_addr_ok = 1'b1;
        #1 chk("rst c1 data_req", 192'(data_req), 192'(1));
        @(negedge clk); data_addr_ok = 1'b0; reset = 1'b1;
        #1 chk("rst c2 data_req", 192'(data_req), 192'(0));
        @(negedge clk); reset = 1'b0; MEM_valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA55AA;
        #1 chk("rst c3 data_req", 192'(data_req), 192'(0));
        chk("rst c3 MEM_over", 192'(MEM_over), 192'(0));
        chk("rst c3 load reg", 192'(MEM_result_quick_get), 192'(0));
        @(negedge clk); data_data_ok = 1'b0;
        #1 chk("rst c4 load reg", 192'(MEM_result_quick_get), 192'(0));
        chk("rst c4 MEM_over", 192'(MEM_over), 192'(0));
        last_rd = '0;
        @(negedge clk);

        // random traffic against the model in run()
        for (int i = 0; i < 150; i++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            e = exe_t'(tmp[166:0]);
            dn = int'($urandom_range(2));
            e.ctl[5] = dn == 1;
            e.ctl[4] = dn == 2;
            e.ctl[3:2] = 2'($urandom_range(2));
            if ($urandom_range(1) == 1) e.exe[1:0] = 2'b00;
            run(e, $urandom, int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(2)), dn, res, wd);
            if ($urandom_range(3) == 0) begin
                MEM_valid = 1'b0;
                #1 chk("gap MEM_over", 192'(MEM_over), 192'(0));
                chk("gap data_req", 192'(data_req), 192'(0));
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
